biriscv_mem_arbiter: RTL and testbench

BIRISCV_MEM_ARBITER -- requirements
Module: biriscv_mem_arbiter

---
 rtl/biriscv_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_biriscv_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_mem_arbiter.sv
// Shared memory-port arbiter for the biRISC-V fetch (I) and data (D) sides.
// Requests are issued in order to a single memory port. A small FIFO tracks
// in-flight requests so each in-order response can be steered to its source.
module biriscv_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  // Instruction fetch side
  input  logic                               i_rd,
  input  logic [31:0]                        i_pc,
  output logic                               i_accept,
  output logic                               i_valid,
  output logic [63:0]                        i_inst,
  // Data side
  input  logic                               d_rd,
  input  logic [3:0]                         d_wr,
  input  logic [31:0]                        d_addr,
  input  logic [31:0]                        d_wdata,
  input  logic [10:0]                        d_req_tag,
  output logic                               d_accept,
  output logic                               d_ack,
  output logic [31:0]                        d_rdata,
  output logic [10:0]                        d_resp_tag,
  // Memory side
  output logic                               mem_req,
  output logic [3:0]                         mem_we,
  output logic [31:0]                        mem_addr,
  output logic [31:0]                        mem_wdata,
  input  logic                               mem_gnt,
  input  logic                               mem_rvalid,
  input  logic [63:0]                        mem_rdata,
  // Status
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_o
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TW = 11;

  // One in-flight request: who asked, which 32-bit half, and the D-side tag
  typedef struct packed {
    logic          src_d;
    logic          addr2;
    logic [TW-1:0] tag;
  } entry_t;

  entry_t        r_mem [MAX_OUTSTANDING];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_err;

  logic   w_d_active;
  logic   w_any_req;
  logic   w_full;
  logic   w_empty;
  logic   w_pop;
  logic   w_can_issue;
  logic   w_starved;
  logic   w_i_win;
  logic   w_issue;
  logic   w_i_issue;
  logic   w_d_issue;
  entry_t w_head;
  entry_t w_push_entry;

  // Arbitration and issue qualification
  always_comb begin
    w_d_active   = d_rd | (|d_wr);
    w_any_req    = i_rd | w_d_active;
    w_full       = (r_count == CW'(MAX_OUTSTANDING));
    w_empty      = (r_count == '0);
    w_pop        = mem_rvalid & ~w_empty;
    // A same-cycle pop frees a slot, so a full FIFO can still take an issue
    w_can_issue  = ~w_full | w_pop;
    w_starved    = (r_starve == SW'(STARVE_LIMIT));
    w_i_win      = i_rd & (~w_d_active | w_starved);
    w_issue      = rst_n & w_any_req & w_can_issue & mem_gnt;
    w_i_issue    = w_issue & w_i_win;
    w_d_issue    = w_issue & ~w_i_win;
    w_head       = r_mem[r_rd_ptr];
    w_push_entry = '{src_d: ~w_i_win, addr2: d_addr[2], tag: d_req_tag};
  end

  // Memory-side request mux and response steering
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    i_accept   = 1'b0;
    d_accept   = 1'b0;
    i_valid    = 1'b0;
    i_inst     = '0;
    d_ack      = 1'b0;
    d_rdata    = '0;
    d_resp_tag = '0;

    if (rst_n && w_any_req && w_can_issue) begin
      mem_req = 1'b1;
      if (w_i_win) begin
        mem_addr = i_pc;
      end else begin
        mem_addr  = d_addr;
        mem_we    = d_wr;
        mem_wdata = d_wdata;
      end
    end
    i_accept = w_i_issue;
    d_accept = w_d_issue;

    if (rst_n && w_pop) begin
      if (w_head.src_d) begin
        d_ack      = 1'b1;
        d_rdata    = w_head.addr2 ? mem_rdata[63:32] : mem_rdata[31:0];
        d_resp_tag = w_head.tag;
      end else begin
        i_valid = 1'b1;
        i_inst  = mem_rdata;
      end
    end
  end

  // Tracking FIFO payload storage (no reset needed, guarded by r_count)
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  // FIFO pointers, occupancy, starvation counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (!i_rd || w_i_issue) begin
        r_starve <= '0;
      end else if (w_d_issue && !w_starved) begin
        r_starve <= r_starve + SW'(1);
      end
      if (mem_rvalid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outstanding = r_count;
  assign err_o       = r_err;

endmodule

// File: tb/tb_biriscv_mem_arbiter.sv
// Directed scoreboard bench for biriscv_mem_arbiter (default parameters).
module tb_biriscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_rd;
  logic [31:0] i_pc;
  logic        i_accept, i_valid;
  logic [63:0] i_inst;
  logic        d_rd;
  logic [3:0]  d_wr;
  logic [31:0] d_addr, d_wdata;
  logic [10:0] d_req_tag;
  logic        d_accept, d_ack;
  logic [31:0] d_rdata;
  logic [10:0] d_resp_tag;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;
  logic [2:0]  outstanding;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_d;
    bit          a2;
    logic [10:0] tag;
  } exp_t;
  exp_t sb[$];

  biriscv_mem_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd(i_rd), .i_pc(i_pc), .i_accept(i_accept), .i_valid(i_valid), .i_inst(i_inst),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_req_tag(d_req_tag),
    .d_accept(d_accept), .d_ack(d_ack), .d_rdata(d_rdata), .d_resp_tag(d_resp_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: drive, settle, check combinational outputs against
  // the scoreboard, record any expected issue, then advance past the edge.
  task automatic cyc(input bit ird, input bit drd, input logic [3:0] dwr,
                     input logic [31:0] daddr, input logic [10:0] tag,
                     input bit gnt, input bit rv, input logic [63:0] rdata,
                     input bit exp_req, input bit exp_i, input bit exp_d);
    exp_t e;
    i_rd       = ird;
    d_rd       = drd;
    d_wr       = dwr;
    d_addr     = daddr;
    d_req_tag  = tag;
    d_wdata    = 32'hC0DE0000 | 32'(tag);
    mem_gnt    = gnt;
    mem_rvalid = rv;
    mem_rdata  = rdata;
    #1;
    chk("mem_req", 64'(mem_req), 64'(exp_req));
    chk("i_accept", 64'(i_accept), 64'(exp_i));
    chk("d_accept", 64'(d_accept), 64'(exp_d));
    if (rv && sb.size() > 0) begin
      e = sb.pop_front();
      chk("i_valid", 64'(i_valid), 64'(!e.is_d));
      chk("d_ack", 64'(d_ack), 64'(e.is_d));
      if (e.is_d) begin
        chk("d_rdata", 64'(d_rdata), e.a2 ? 64'(rdata[63:32]) : 64'(rdata[31:0]));
        chk("d_resp_tag", 64'(d_resp_tag), 64'(e.tag));
      end else begin
        chk("i_inst", i_inst, rdata);
      end
    end else begin
      chk("no_i_valid", 64'(i_valid), 64'd0);
      chk("no_d_ack", 64'(d_ack), 64'd0);
    end
    if (exp_i) begin
      chk("i_mem_addr", 64'(mem_addr), 64'(i_pc));
      chk("i_mem_we", 64'(mem_we), 64'd0);
      sb.push_back('{is_d: 1'b0, a2: 1'b0, tag: 11'd0});
    end
    if (exp_d) begin
      chk("d_mem_addr", 64'(mem_addr), 64'(daddr));
      chk("d_mem_we", 64'(mem_we), 64'(dwr));
      chk("d_mem_wdata", 64'(mem_wdata), 64'(32'hC0DE0000 | 32'(tag)));
      sb.push_back('{is_d: 1'b1, a2: daddr[2], tag: tag});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 4'h0, 32'h0, 11'h0, 0, 0, 64'h0, 0, 0, 0);
  endtask

  task automatic respond(input logic [63:0] rdata);
    cyc(0, 0, 4'h0, 32'h0, 11'h0, 0, 1, rdata, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_pc  = 32'h80000000;
    // Requests are active during reset; everything must stay quiet
    i_rd = 1'b1; d_rd = 1'b1; d_wr = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    d_req_tag = 11'h0; mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 64'h0;
    #12;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_i_accept", 64'(i_accept), 64'd0);
    chk("rst_d_accept", 64'(d_accept), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single D read, response two cycles later from the upper half
    cyc(0, 1, 4'h0, 32'h80000004, 11'h05, 1, 0, 64'h0, 1, 0, 1);
    chk("single_outstanding", 64'(outstanding), 64'd1);
    idle();
    respond(64'h11112222_33334444);
    chk("single_drain", 64'(outstanding), 64'd0);

    // Contention: 8 D wins, then a forced I win, then D wins again
    for (int k = 0; k < 10; k++) begin
      cyc(1, 1, 4'h0, 32'h1000 + 32'(k * 4), 11'(k), 1, (k > 0),
          {32'hA0000000 + 32'(k), 32'hB0000000 + 32'(k)}, 1, (k == 8), (k != 8));
    end
    respond(64'hFEEDFACE_CAFEF00D);
    chk("contend_drain", 64'(outstanding), 64'd0);

    // Fill the FIFO: oldest is an I fetch, then three D reads
    cyc(1, 0, 4'h0, 32'h0, 11'h0, 1, 0, 64'h0, 1, 1, 0);
    cyc(0, 1, 4'h0, 32'h3000, 11'd11, 1, 0, 64'h0, 1, 0, 1);
    cyc(0, 1, 4'h0, 32'h3004, 11'd12, 1, 0, 64'h0, 1, 0, 1);
    cyc(0, 1, 4'h0, 32'h3008, 11'd13, 1, 0, 64'h0, 1, 0, 1);
    chk("full_outstanding", 64'(outstanding), 64'd4);
    // Full with no response: no request, no accept
    cyc(0, 1, 4'h0, 32'h300C, 11'd14, 1, 0, 64'h0, 0, 0, 0);
    chk("full_hold", 64'(outstanding), 64'd4);
    respond(64'h01234567_89ABCDEF);
    chk("full_pop", 64'(outstanding), 64'd3);
    cyc(0, 1, 4'h0, 32'h300C, 11'd14, 1, 0, 64'h0, 1, 0, 1);
    chk("full_refill", 64'(outstanding), 64'd4);
    // Push and pop together while full
    cyc(1, 0, 4'h0, 32'h0, 11'h0, 1, 1, 64'h55556666_77778888, 1, 1, 0);
    chk("pushpop_outstanding", 64'(outstanding), 64'd4);
    respond(64'h10000001_20000002);
    respond(64'h30000003_40000004);
    respond(64'h50000005_60000006);
    respond(64'h70000007_80000008);
    chk("full_drain", 64'(outstanding), 64'd0);

    // Request without grant: mem_req up, no accept
    cyc(0, 1, 4'h0, 32'h4000, 11'd7, 0, 0, 64'h0, 1, 0, 0);
    chk("nognt_outstanding", 64'(outstanding), 64'd0);

    // Order mix: I fetch, D write, D read
    cyc(1, 0, 4'h0, 32'h0, 11'h0, 1, 0, 64'h0, 1, 1, 0);
    cyc(0, 0, 4'hF, 32'h2000, 11'd3, 1, 0, 64'h0, 1, 0, 1);
    cyc(0, 1, 4'h0, 32'h2004, 11'd4, 1, 0, 64'h0, 1, 0, 1);
    respond(64'hAAAA0001_BBBB0001);
    respond(64'hAAAA0002_BBBB0002);
    respond(64'hAAAA0003_BBBB0003);
    chk("mix_drain", 64'(outstanding), 64'd0);
    chk("mix_err", 64'(err_o), 64'd0);

    // Spurious response with nothing outstanding
    respond(64'hDEADBEEF_DEADBEEF);
    chk("spur_err", 64'(err_o), 64'd1);
    chk("spur_outstanding", 64'(outstanding), 64'd0);
    idle();
    chk("spur_err_sticky", 64'(err_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("spur_err_reset", 64'(err_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-operation drops in-flight entries
    cyc(0, 1, 4'h0, 32'h5000, 11'd21, 1, 0, 64'h0, 1, 0, 1);
    cyc(0, 1, 4'h0, 32'h5004, 11'd22, 1, 0, 64'h0, 1, 0, 1);
    chk("midrst_outstanding", 64'(outstanding), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_cleared", 64'(outstanding), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    respond(64'h12345678_9ABCDEF0);
    chk("midrst_err", 64'(err_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
